// File: rtl/i2c_write_arbiter.sv
// Round-robin arbiter sharing one 16-bit I2C write engine among NREQ requesters, with NACK retry and timeouts.
// Latency: req to wr_start 1 cycle; completion to next wr_start at least 2 cycles.
// Backpressure: requesters hold req until their cpl_valid; no grant while the writer reports wr_done=0.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   req, req_data          level request per requester and its packed 16-bit words
//   cpl_valid/id/status    one-cycle completion pulse: 00 ok, 01 nack after retries, 10 timeout
//   busy                   high from grant until the completion cycle
//   wr_start, wr_data      start request and word to the write engine
//   wr_done, wr_ack        write engine idle level and both-bytes-acked flag (valid while wr_done=1)
module i2c_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int MAX_RETRY = 2,
  parameter int RETRY_GAP = 1000,
  parameter int LAUNCH_TO = 2048,
  parameter int BUSY_TO   = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  output logic                 cpl_valid,
  output logic [ID_W-1:0]      cpl_id,
  output logic [1:0]           cpl_status,
  output logic                 busy,
  output logic                 wr_start,
  output logic [15:0]          wr_data,
  input  logic                 wr_done,
  input  logic                 wr_ack
);

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_CHECK,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        retry;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   rr;
  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic [1:0]        status_q;
  logic [1:0]        status_nxt;
  logic [15:0]       data_q;
  logic [15:0]       data_sel;
  int                idx;

  // Round-robin search: walk from rr upward; iterating k downward lets the
  // nearest set bit (smallest offset) overwrite the others.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[ID_W'(idx)]) begin
        pick     = ID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign data_sel = req_data[{pick, 4'b0000} +: 16];

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    wr_start   = 1'b0;
    cpl_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        // The writer may still be finishing after a timeout, so wait for idle.
        if (pick_vld && wr_done) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        wr_start = 1'b1;
        busy     = 1'b1;
        if (!wr_done) begin
          state_nxt = S_BUSY;
        end else if (cnt == CNT_W'(LAUNCH_TO - 1)) begin
          state_nxt  = S_DONE;
          status_nxt = 2'b10;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (wr_done) begin
          state_nxt = S_CHECK;
        end else if (cnt == CNT_W'(BUSY_TO - 1)) begin
          state_nxt  = S_DONE;
          status_nxt = 2'b10;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (wr_ack) begin
          state_nxt  = S_DONE;
          status_nxt = 2'b00;
        end else if (retry < 3'(MAX_RETRY)) begin
          state_nxt = S_GAP;
        end else begin
          state_nxt  = S_DONE;
          status_nxt = 2'b01;
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (cnt == CNT_W'(RETRY_GAP - 1)) state_nxt = S_LAUNCH;
      end
      S_DONE: begin
        cpl_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      retry    <= '0;
      grant    <= '0;
      rr       <= '0;
      status_q <= 2'b00;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
      // One counter serves every timed state; it restarts on each state change.
      if (state_nxt != state || state == S_IDLE) cnt <= '0;
      else                                       cnt <= cnt + 1'b1;
      if (state == S_IDLE && state_nxt == S_LAUNCH) begin
        grant  <= pick;
        data_q <= data_sel;
        retry  <= '0;
      end
      if (state == S_CHECK && state_nxt == S_GAP) retry <= retry + 1'b1;
      if (state == S_DONE) rr <= (grant == ID_W'(NREQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign wr_data    = data_q;
  assign cpl_id     = grant;
  assign cpl_status = status_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Bench for i2c_write_arbiter: random and directed requests against a writer model and a queue scoreboard.
// Latency: completion order and start counts predicted when requests are issued.
// Backpressure: requesters hold req until their own cpl_valid.
module tb_i2c_write_arbiter;

  localparam int NREQ      = 4;
  localparam int ID_W      = 2;
  localparam int MAX_RETRY = 2;
  localparam int RETRY_GAP = 20;
  localparam int LAUNCH_TO = 40;
  localparam int BUSY_TO   = 150;

  typedef struct {
    int          id;
    logic [15:0] word;
    int          status;
    int          starts;
    int          lmin;
    int          lmax;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] req_data;
  logic              cpl_valid;
  logic [ID_W-1:0]   cpl_id;
  logic [1:0]        cpl_status;
  logic              busy;
  logic              wr_start;
  logic [15:0]       wr_data;
  logic              wr_done;
  logic              wr_ack;

  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  int   wmode = 0;        // 0 normal writer, 1 never drops wr_done, 2 never raises wr_done
  int   rr_m  = 0;        // reference round-robin pointer
  logic [15:0] word_tab [NREQ];
  int          nack_tab [NREQ];
  exp_t exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  i2c_write_arbiter #(
    .NREQ(NREQ), .ID_W(ID_W), .MAX_RETRY(MAX_RETRY),
    .RETRY_GAP(RETRY_GAP), .LAUNCH_TO(LAUNCH_TO), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_status(cpl_status), .busy(busy),
    .wr_start(wr_start), .wr_data(wr_data), .wr_done(wr_done), .wr_ack(wr_ack)
  );

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Writer model: NACKs the first nack_tab[id] attempts of a word, then acks.
  initial begin : writer
    int ph, cnt, att;
    bit ack;
    wr_done = 1'b1; wr_ack = 1'b0;
    ph = 0; cnt = 0; att = 0; ack = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        ph = 0; wr_done = 1'b1; wr_ack = 1'b0; att = 0;
      end else begin
        if (cpl_valid) att = 0;
        case (ph)
          0: if (wr_start && wr_done && wmode != 1) begin
               att++;
               ack = 1'b1;
               for (int i = 0; i < NREQ; i++)
                 if (word_tab[i] == wr_data && att <= nack_tab[i]) ack = 1'b0;
               ph  = 1;
               cnt = $urandom_range(0, 3);
             end
          1: if (cnt == 0) begin
               wr_done = 1'b0; wr_ack = 1'b0; ph = 2; cnt = $urandom_range(2, 8);
             end else cnt--;
          default: if (wmode != 2) begin
               if (cnt == 0) begin wr_done = 1'b1; wr_ack = ack; ph = 0; end
               else cnt--;
             end
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on each new transaction's completion.
  initial begin : monitor
    bit   prev_s, in_txn;
    int   n_starts, t_first, t_last, t_cpl;
    exp_t h;
    prev_s = 0; in_txn = 0; n_starts = 0; t_first = 0; t_last = 0; t_cpl = -100;
    h = '{id: 0, word: 16'h0, status: 0, starts: 0, lmin: 0, lmax: 0};
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        in_txn = 0; prev_s = 0;
      end else begin
        if (wr_start && !prev_s) begin
          if (!in_txn) begin
            if (exp_q.size() == 0) begin
              chk(1'b0, "unexpected_start", wr_data, 0);
            end else begin
              h = exp_q[0]; in_txn = 1; n_starts = 1; t_first = cycle;
              chk(wr_data == h.word, "start_word", wr_data, h.word);
              chk(busy == 1'b1, "busy_at_start", busy, 1);
              chk(cycle - t_cpl >= 2, "cpl_to_start_spacing", cycle - t_cpl, 2);
            end
          end else begin
            n_starts++;
            chk(wr_data == h.word, "retry_word", wr_data, h.word);
            chk(cycle - t_last >= RETRY_GAP, "retry_gap", cycle - t_last, RETRY_GAP);
          end
          t_last = cycle;
        end
        if (cpl_valid) begin
          if (!in_txn || exp_q.size() == 0) begin
            chk(1'b0, "unexpected_cpl", cpl_id, 0);
          end else begin
            h = exp_q.pop_front();
            chk(int'(cpl_id) == h.id, "cpl_id", cpl_id, h.id);
            chk(int'(cpl_status) == h.status, "cpl_status", cpl_status, h.status);
            chk(n_starts == h.starts, "start_count", n_starts, h.starts);
            chk(wr_data == h.word, "word_at_cpl", wr_data, h.word);
            chk(busy == 1'b0, "busy_at_cpl", busy, 0);
            chk(cycle - t_first >= h.lmin && cycle - t_first <= h.lmax,
                "cpl_latency", cycle - t_first, h.lmin);
          end
          in_txn = 0; t_cpl = cycle;
        end
        prev_s = wr_start;
      end
    end
  end

  // One cycle step for the driver; requesters release req on their completion.
  task automatic tick();
    @(posedge clk); #1;
    if (cpl_valid) req[cpl_id] = 1'b0;
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < NREQ; i++) begin word_tab[i] = 16'h0; nack_tab[i] = 0; end
  endtask

  task automatic set_word(input int id, input logic [15:0] w, input int nack);
    word_tab[id] = w;
    nack_tab[id] = nack;
    req_data[16*id +: 16] = w;
  endtask

  // Predicts service order: held requests are served in ascending order from rr, wrapping.
  task automatic issue_set(input logic [NREQ-1:0] set, input int ovr, input int lmin, input int lmax);
    int   last, id;
    exp_t e;
    last = -1;
    for (int k = 0; k < NREQ; k++) begin
      id = (rr_m + k) % NREQ;
      if (set[id[1:0]]) begin
        e.id = id; e.word = word_tab[id]; e.lmin = lmin; e.lmax = lmax;
        if (ovr >= 0) begin
          e.status = ovr; e.starts = 1;
        end else if (nack_tab[id] > MAX_RETRY) begin
          e.status = 1; e.starts = MAX_RETRY + 1;
        end else begin
          e.status = 0; e.starts = nack_tab[id] + 1;
        end
        exp_q.push_back(e);
        last = id;
      end
    end
    if (last >= 0) rr_m = (last + 1) % NREQ;
    req = req | set;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || req != 0) && n < budget) begin tick(); n++; end
    chk(n < budget, name, n, budget);
    tick(); tick();
  endtask

  task automatic wait_busy_phase(input string name);
    int n;
    n = 0;
    while (!(busy && !wr_start && !wr_done) && n < 100) begin tick(); n++; end
    chk(n < 100, name, n, 100);
  endtask

  initial begin : driver
    int n, seen;
    logic [NREQ-1:0] set;
    reset = 1'b1; req = '0; req_data = '0;
    clear_tabs();
    repeat (3) tick();
    chk(wr_start == 1'b0, "rst_wr_start", wr_start, 0);
    chk(wr_data == 16'h0, "rst_wr_data", wr_data, 0);
    chk(cpl_valid == 1'b0, "rst_cpl_valid", cpl_valid, 0);
    chk(cpl_id == '0, "rst_cpl_id", cpl_id, 0);
    chk(cpl_status == 2'b00, "rst_cpl_status", cpl_status, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Single request, first-start latency.
    set_word(0, 16'h3A55, 0);
    issue_set(4'b0001, -1, 0, 100000);
    tick();
    chk(wr_start == 1'b1, "req_to_start_latency", wr_start, 1);
    wait_idle(500, "single_done");

    // All four held, two full rounds.
    clear_tabs();
    for (int i = 0; i < NREQ; i++) set_word(i, 16'h1000 * (i + 1) + 16'h00A5, 0);
    issue_set(4'b1111, -1, 0, 100000);
    wait_idle(2000, "round1_done");
    for (int i = 0; i < NREQ; i++) set_word(i, 16'h1000 * (i + 5) + 16'h005A, 0);
    issue_set(4'b1111, -1, 0, 100000);
    wait_idle(2000, "round2_done");

    // Persistent NACK, then ack on second attempt.
    clear_tabs();
    set_word(2, 16'hC0DE, 3);
    issue_set(4'b0100, -1, 0, 100000);
    wait_idle(2000, "nack_all_done");
    set_word(2, 16'hBEEF, 1);
    issue_set(4'b0100, -1, 0, 100000);
    wait_idle(2000, "nack_once_done");

    // Random batches.
    repeat (6) begin
      clear_tabs();
      set = NREQ'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        if (set[i]) set_word(i, {4'(i), 12'($urandom)}, $urandom_range(0, 3));
      issue_set(set, -1, 0, 100000);
      wait_idle(4000, "rand_batch_done");
    end

    // Lone requester reasserting the cycle after its completion.
    clear_tabs();
    set_word(0, 16'h0111, 0);
    issue_set(4'b0001, -1, 0, 100000);
    n = 0;
    while (!cpl_valid && n < 300) begin tick(); n++; end
    chk(n < 300, "lone_first_cpl", n, 300);
    tick();
    set_word(0, 16'h0222, 0);
    issue_set(4'b0001, -1, 0, 100000);
    wait_idle(500, "lone_second_done");

    // Launch timeout: writer never acknowledges start.
    clear_tabs();
    wmode = 1;
    set_word(1, 16'h7711, 0);
    issue_set(4'b0010, 2, LAUNCH_TO - 1, LAUNCH_TO + 1);
    wait_idle(500, "launch_to_done");
    wmode = 0;

    // Busy timeout: writer never finishes; no new grant until it goes idle.
    clear_tabs();
    wmode = 2;
    set_word(2, 16'h7722, 0);
    issue_set(4'b0100, 2, BUSY_TO, BUSY_TO + 8);
    wait_idle(1000, "busy_to_done");
    set_word(3, 16'h7733, 0);
    issue_set(4'b1000, -1, 0, 100000);
    seen = 0;
    repeat (30) begin tick(); if (wr_start) seen++; end
    chk(seen == 0, "no_grant_while_wr_done_low", seen, 0);
    wmode = 0;
    wait_idle(500, "after_busy_to_done");

    // req_data changed and req dropped during BUSY.
    clear_tabs();
    set_word(1, 16'h5AA5, 0);
    issue_set(4'b0010, -1, 0, 100000);
    wait_busy_phase("reach_busy_data_chg");
    req_data[31:16] = 16'hA55A;
    req[1] = 1'b0;
    wait_idle(500, "data_chg_done");

    // Reset during BUSY with rr pointing at 2, then rr must restart from 0.
    clear_tabs();
    set_word(1, 16'h6611, 0);
    issue_set(4'b0010, -1, 0, 100000);
    wait_idle(500, "pre_reset_done");
    set_word(2, 16'h6622, 0);
    issue_set(4'b0100, -1, 0, 100000);
    wait_busy_phase("reach_busy_reset");
    exp_q.delete();
    reset = 1'b1;
    tick();
    chk(wr_start == 1'b0, "reset_mid_wr_start", wr_start, 0);
    chk(busy == 1'b0, "reset_mid_busy", busy, 0);
    chk(cpl_valid == 1'b0, "reset_mid_cpl", cpl_valid, 0);
    tick();
    reset = 1'b0;
    req = '0;
    rr_m = 0;
    tick(); tick();
    clear_tabs();
    set_word(0, 16'h6600, 0);
    set_word(3, 16'h6633, 0);
    issue_set(4'b1001, -1, 0, 100000);
    wait_idle(1000, "post_reset_rr_done");
    set_word(2, 16'h6644, 0);
    issue_set(4'b0100, -1, 0, 100000);
    wait_idle(500, "post_reset_id2_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
